// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: FSM states,
// register offsets and STATUS bit positions.
package uart_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } uart_state_e;

  localparam logic [31:0] TXDATA_OFS = 32'h0000_0000;
  localparam logic [31:0] STATUS_OFS = 32'h0000_0004;

  localparam int unsigned STATUS_ACTIVE_BIT = 0;
  localparam int unsigned STATUS_FULL_BIT   = 1;
  localparam int unsigned STATUS_OVF_BIT    = 2;

endpackage

// File: rtl/baud_gen.sv
// Bit-period timer: counts CLKS_PER_BIT-1 down to 0 and flags the last cycle
// of each bit; restart realigns the period to the next cycle.
module baud_gen #(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (restart || (r_cnt == '0)) begin
      r_cnt <= CntMax;
    end else begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign tick = (r_cnt == '0);

endmodule

// File: rtl/uart_tx_mmio.sv
// 8N1 UART transmitter behind two memory-mapped words (TXDATA, STATUS) with a
// one-entry holding buffer so consecutive frames go out back to back.
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_FFD0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dmem_wren,
  input  logic [31:0] dmem_address,
  input  logic [31:0] dmem_data_in,
  input  logic [2:0]  funct3,
  output logic [31:0] dmem_data_out,
  output logic        tx,
  output logic        busy
);

  uart_state_e r_state, w_state_d;
  logic [7:0]  r_shift, w_shift_d;
  logic [7:0]  r_buf, w_buf_d;
  logic [2:0]  r_idx, w_idx_d;
  logic        r_full, w_full_d;
  logic        r_ovf, w_ovf_d;
  logic [31:0] r_rdata;

  logic        w_tick, w_restart;
  logic        w_sel, w_sel_status, w_wr_tx, w_wr_st;
  logic        w_active, w_stop_end, w_buf_accept;
  logic [2:0]  w_status;
  logic        w_unused;

  baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_gen (
    .clk    (clk),
    .reset  (reset),
    .restart(w_restart),
    .tick   (w_tick)
  );

  assign w_sel        = (dmem_address[31:3] == BASE_ADDR[31:3]);
  assign w_sel_status = w_sel && (dmem_address[2] == STATUS_OFS[2]);
  assign w_wr_tx      = dmem_wren && w_sel && (dmem_address[2] == TXDATA_OFS[2]);
  assign w_wr_st      = dmem_wren && w_sel_status;
  assign w_active     = (r_state != StIdle);
  assign w_stop_end   = (r_state == StStop) && w_tick;

  // On the last stop cycle a full buffer drains into the shifter, freeing it
  // for the incoming byte; an empty one lets the byte bypass straight in.
  assign w_buf_accept = w_wr_tx && w_active && (r_full == w_stop_end);

  always_comb begin
    w_status                    = '0;
    w_status[STATUS_ACTIVE_BIT] = w_active;
    w_status[STATUS_FULL_BIT]   = r_full;
    w_status[STATUS_OVF_BIT]    = r_ovf;
  end

  always_comb begin
    w_state_d = r_state;
    w_shift_d = r_shift;
    w_idx_d   = r_idx;
    w_buf_d   = r_buf;
    w_full_d  = r_full;
    w_ovf_d   = r_ovf;
    w_restart = 1'b0;

    case (r_state)
      StIdle: begin
        if (w_wr_tx) begin
          w_state_d = StStart;
          w_shift_d = dmem_data_in[7:0];
          w_restart = 1'b1;
        end
      end
      StStart: begin
        if (w_tick) begin
          w_state_d = StData;
          w_idx_d   = '0;
        end
      end
      StData: begin
        if (w_tick) begin
          w_shift_d = {1'b0, r_shift[7:1]};
          w_idx_d   = r_idx + 3'd1;
          if (r_idx == 3'd7) begin
            w_state_d = StStop;
          end
        end
      end
      StStop: begin
        if (w_tick) begin
          if (r_full) begin
            w_state_d = StStart;
            w_shift_d = r_buf;
            w_full_d  = 1'b0;
          end else if (w_wr_tx) begin
            w_state_d = StStart;
            w_shift_d = dmem_data_in[7:0];
          end else begin
            w_state_d = StIdle;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase

    if (w_buf_accept) begin
      w_buf_d  = dmem_data_in[7:0];
      w_full_d = 1'b1;
    end

    // A dropped byte sets overflow even if the same cycle asks to clear it.
    if (w_wr_st && dmem_data_in[STATUS_OVF_BIT]) begin
      w_ovf_d = 1'b0;
    end
    if (w_wr_tx && w_active && r_full && !w_stop_end) begin
      w_ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
      r_shift <= '0;
      r_buf   <= '0;
      r_idx   <= '0;
      r_full  <= 1'b0;
      r_ovf   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_d;
      r_shift <= w_shift_d;
      r_buf   <= w_buf_d;
      r_idx   <= w_idx_d;
      r_full  <= w_full_d;
      r_ovf   <= w_ovf_d;
      r_rdata <= w_sel_status ? {29'b0, w_status} : 32'b0;
    end
  end

  always_comb begin
    case (r_state)
      StStart: tx = 1'b0;
      StData:  tx = r_shift[0];
      default: tx = 1'b1;
    endcase
  end

  assign busy          = w_active || r_full;
  assign dmem_data_out = r_rdata;

  // Width code and low address/data bits do not affect byte stores.
  assign w_unused = ^{funct3, dmem_data_in[31:8], dmem_address[1:0]};

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: address-decode vector table, directed
// multi-frame sequences and random traffic against a frame-timing model.
module tb_uart_tx_mmio;

  localparam int          N     = 4;
  localparam int          FRAME = 10 * N;
  localparam logic [31:0] BASE  = 32'hFFFF_FFD0;
  localparam logic [31:0] TXA   = BASE;
  localparam logic [31:0] STA   = BASE + 32'd4;
  localparam logic [31:0] OFFA  = BASE + 32'd8;

  logic        clk = 1'b0;
  logic        reset, wren;
  logic [31:0] addr, din, dout;
  logic [2:0]  f3;
  logic        tx, busy;

  always #5 clk = ~clk;

  uart_tx_mmio #(
    .CLKS_PER_BIT(N),
    .BASE_ADDR   (BASE)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .dmem_wren    (wren),
    .dmem_address (addr),
    .dmem_data_in (din),
    .funct3       (f3),
    .dmem_data_out(dout),
    .tx           (tx),
    .busy         (busy)
  );

  int checks = 0;
  int errors = 0;

  // Model: a frame is a start edge index plus a byte; line level is derived
  // from elapsed cycles since that edge.
  int          e = 0;
  logic        m_frame = 1'b0;
  int          m_t0 = 0;
  logic [7:0]  m_byte = 8'h00;
  logic [7:0]  m_buf = 8'h00;
  logic        m_full = 1'b0;
  logic        m_ovf = 1'b0;
  logic        m_tx = 1'b1;
  logic        m_busy = 1'b0;
  logic [31:0] m_rdata = 32'h0;

  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k >= 9) return 1'b1;
    return b[k-1];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, e);
    end
  endtask

  task automatic model_step();
    logic       sel, wr_tx, wr_st, act_old, fend, full_old, taken, ovf_set, act_now;
    logic [7:0] d8;
    e++;
    act_old = m_frame && ((e - 1 - m_t0) < FRAME);
    sel     = (addr[31:3] == BASE[31:3]);
    if (reset) begin
      m_frame = 1'b0;
      m_full  = 1'b0;
      m_ovf   = 1'b0;
      m_rdata = 32'h0;
    end else begin
      m_rdata  = (sel && addr[2]) ? {29'b0, m_ovf, m_full, act_old} : 32'h0;
      wr_tx    = wren && sel && !addr[2];
      wr_st    = wren && sel && addr[2];
      d8       = din[7:0];
      fend     = m_frame && ((e - m_t0) == FRAME);
      full_old = m_full;
      taken    = 1'b0;
      ovf_set  = 1'b0;
      if (fend) begin
        if (full_old) begin
          m_t0 = e; m_byte = m_buf; m_full = 1'b0;
        end else if (wr_tx) begin
          m_t0 = e; m_byte = d8; taken = 1'b1;
        end else begin
          m_frame = 1'b0;
        end
      end
      if (wr_tx && !taken) begin
        if (!act_old) begin
          m_frame = 1'b1; m_t0 = e; m_byte = d8;
        end else if (!full_old || fend) begin
          m_buf = d8; m_full = 1'b1;
        end else begin
          ovf_set = 1'b1;
        end
      end
      if (wr_st && din[2]) m_ovf = 1'b0;
      if (ovf_set) m_ovf = 1'b1;
    end
    act_now = m_frame && ((e - m_t0) < FRAME);
    m_tx    = act_now ? frame_bit(m_byte, (e - m_t0) / N) : 1'b1;
    m_busy  = act_now || m_full;
  endtask

  task automatic cyc(input logic rst, input logic wr, input logic [31:0] a,
                     input logic [31:0] d);
    reset = rst;
    wren  = wr;
    addr  = a;
    din   = d;
    f3    = 3'($urandom_range(0, 7));
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("model_tx", tx, m_tx);
    chk("model_busy", busy, m_busy);
    chk("model_rdata", dout, m_rdata);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  typedef struct {
    logic [31:0] wa;
    logic [31:0] wd;
    logic [31:0] ra;
    logic        exp_tx;
    logic        exp_busy;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t       vecs[8];
  logic [9:0] pat;

  initial begin
    vecs[0] = '{TXA,           32'h12, STA,           1'b0, 1'b1, 32'd1};
    vecs[1] = '{OFFA,          32'h12, OFFA,          1'b1, 1'b0, 32'd0};
    vecs[2] = '{BASE + 32'd3,  32'h00, STA,           1'b0, 1'b1, 32'd1};
    vecs[3] = '{STA,           32'hFF, STA,           1'b1, 1'b0, 32'd0};
    vecs[4] = '{32'hFFFF_FFCC, 32'h34, 32'hFFFF_FFCC, 1'b1, 1'b0, 32'd0};
    vecs[5] = '{32'hFFFF_FFDC, 32'h56, 32'hFFFF_FFDC, 1'b1, 1'b0, 32'd0};
    vecs[6] = '{BASE + 32'd1,  32'h78, TXA,           1'b0, 1'b1, 32'd0};
    vecs[7] = '{BASE + 32'd2,  32'h9A, BASE + 32'd6,  1'b0, 1'b1, 32'd1};
    pat = 10'b10_1010_1010;

    reset = 1'b1; wren = 1'b0; addr = 32'h0; din = 32'h0; f3 = 3'd0;
    repeat (3) cyc(1'b1, 1'b0, 32'h0, 32'h0);
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rdata", dout, 32'h0);
    cyc(1'b0, 1'b0, STA, 32'h0);
    chk("rst_status", dout, 32'h0);

    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0, 32'h0, 32'h0);
      cyc(1'b0, 1'b1, vecs[i].wa, vecs[i].wd);
      chk($sformatf("vec%0d_tx", i), tx, vecs[i].exp_tx);
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
      cyc(1'b0, 1'b0, vecs[i].ra, 32'h0);
      chk($sformatf("vec%0d_rd", i), dout, vecs[i].exp_rd);
    end

    // Single 0x55 frame.
    cyc(1'b1, 1'b0, 32'h0, 32'h0);
    for (int t = 0; t <= FRAME; t++) begin
      if (t == 0) cyc(1'b0, 1'b1, TXA, 32'h55);
      else idle();
      if (t < FRAME) begin
        chk("f55_tx", tx, pat[t/N]);
        chk("f55_busy", busy, 1'b1);
      end else begin
        chk("f55_done", busy, 1'b0);
      end
    end

    // 0xA3 then buffered 0x0F, back to back.
    cyc(1'b1, 1'b0, 32'h0, 32'h0);
    for (int t = 0; t <= 2 * FRAME; t++) begin
      if (t == 0) cyc(1'b0, 1'b1, TXA, 32'hA3);
      else if (t == 5) cyc(1'b0, 1'b1, TXA, 32'h0F);
      else if (t == 6) cyc(1'b0, 1'b0, STA, 32'h0);
      else idle();
      if (t == 6) chk("two_status", dout, 32'd3);
      if (t < FRAME) chk("two_tx_a", tx, frame_bit(8'hA3, t / N));
      else if (t < 2 * FRAME) chk("two_tx_b", tx, frame_bit(8'h0F, (t - FRAME) / N));
      else chk("two_done", busy, 1'b0);
    end

    // Third write dropped, overflow set then cleared.
    cyc(1'b1, 1'b0, 32'h0, 32'h0);
    for (int t = 0; t <= 2 * FRAME; t++) begin
      if (t == 0) cyc(1'b0, 1'b1, TXA, 32'h11);
      else if (t == 2) cyc(1'b0, 1'b1, TXA, 32'h22);
      else if (t == 4) cyc(1'b0, 1'b1, TXA, 32'h33);
      else if (t == 5 || t == 8) cyc(1'b0, 1'b0, STA, 32'h0);
      else if (t == 7) cyc(1'b0, 1'b1, STA, 32'h4);
      else idle();
      if (t == 5) chk("ovf_status", dout, 32'd7);
      if (t == 8) chk("ovf_cleared", dout, 32'd3);
      if (t < FRAME) chk("ovf_tx_a", tx, frame_bit(8'h11, t / N));
      else if (t < 2 * FRAME) chk("ovf_tx_b", tx, frame_bit(8'h22, (t - FRAME) / N));
      else chk("ovf_done", busy, 1'b0);
    end

    // Write on the final stop cycle while full is accepted.
    cyc(1'b1, 1'b0, 32'h0, 32'h0);
    for (int t = 0; t <= 3 * FRAME; t++) begin
      if (t == 0) cyc(1'b0, 1'b1, TXA, 32'h11);
      else if (t == 2) cyc(1'b0, 1'b1, TXA, 32'h22);
      else if (t == FRAME) cyc(1'b0, 1'b1, TXA, 32'h33);
      else if (t == FRAME + 1) cyc(1'b0, 1'b0, STA, 32'h0);
      else idle();
      if (t == FRAME + 1) chk("edge_status", dout, 32'd3);
      if (t < FRAME) chk("edge_tx_a", tx, frame_bit(8'h11, t / N));
      else if (t < 2 * FRAME) chk("edge_tx_b", tx, frame_bit(8'h22, (t - FRAME) / N));
      else if (t < 3 * FRAME) chk("edge_tx_c", tx, frame_bit(8'h33, (t - 2 * FRAME) / N));
      else chk("edge_done", busy, 1'b0);
    end

    // Reset mid-frame (with a write that must be ignored), then a clean frame.
    cyc(1'b1, 1'b0, 32'h0, 32'h0);
    for (int t = 0; t <= 17 + FRAME; t++) begin
      if (t == 0) cyc(1'b0, 1'b1, TXA, 32'hFF);
      else if (t == 15) cyc(1'b1, 1'b1, TXA, 32'h00);
      else if (t == 16) cyc(1'b0, 1'b0, STA, 32'h0);
      else if (t == 17) cyc(1'b0, 1'b1, TXA, 32'h01);
      else idle();
      if (t < 15) chk("rstmid_tx_ff", tx, frame_bit(8'hFF, t / N));
      else if (t == 15) begin
        chk("rstmid_tx", tx, 1'b1);
        chk("rstmid_busy", busy, 1'b0);
      end else if (t == 16) chk("rstmid_status", dout, 32'd0);
      else if (t < 17 + FRAME) chk("rstmid_tx_01", tx, frame_bit(8'h01, (t - 17) / N));
      else chk("rstmid_done", busy, 1'b0);
    end

    // Random traffic against the model.
    cyc(1'b1, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 4000; i++) begin
      int unsigned r;
      logic [31:0] a;
      r = $urandom_range(0, 999);
      case ($urandom_range(0, 3))
        0:       a = TXA | 32'($urandom_range(0, 3));
        1:       a = STA | 32'($urandom_range(0, 3));
        2:       a = OFFA;
        default: a = $urandom;
      endcase
      if (r < 2) cyc(1'b1, 1'($urandom_range(0, 1)), a, $urandom);
      else if (r < 150) cyc(1'b0, 1'b1, a, $urandom);
      else cyc(1'b0, 1'b0, a, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_mmio.md
UART_TX_MMIO -- requirements
Module: uart_tx_mmio

Interface
REQ-001 Parameter CLKS_PER_BIT, default 104, SHALL set the clk cycles per serial bit (12 MHz / 115200).
REQ-002 Parameter BASE_ADDR, default 32'hFFFF_FFD0, SHALL set the word address of TXDATA; STATUS SHALL be at BASE_ADDR+4.
REQ-003 clk  input  1  sole clock; all state SHALL change on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 dmem_wren  input  1  store strobe from the data-memory port.
REQ-006 dmem_address  input  32  byte address of the current data access.
REQ-007 dmem_data_in  input  32  store data.
REQ-008 funct3  input  3  load/store width code; stores SHALL use bits [7:0] for any width.
REQ-009 dmem_data_out  output  32  read data for mapped registers.
REQ-010 tx  output  1  serial line; idle high.
REQ-011 busy  output  1  high whenever the FSM is not IDLE or the holding buffer is full.

Function
REQ-012 Select SHALL be dmem_address[31:3] == BASE_ADDR[31:3]; bit [2] SHALL choose TXDATA (0) or STATUS (1); bits [1:0] SHALL be ignored.
REQ-013 Read latency SHALL be one cycle: dmem_data_out registers the STATUS value (or 0 for TXDATA or an unselected address) from the previous cycle's address.
REQ-014 STATUS SHALL read {29'b0, overflow, buf_full, active}, where active is FSM != IDLE.
REQ-015 Frame SHALL be 1 start bit (0), 8 data bits LSB first, and 1 stop bit (1), with each bit held exactly CLKS_PER_BIT cycles (10*CLKS_PER_BIT per frame).
REQ-016 FSM states SHALL be IDLE, START, DATA, STOP. IDLE->START on load; START->DATA after one bit; DATA->STOP after bit index 7; STOP->START if buf_full at stop end (buffer loads into the shifter, buf_full clears), else STOP->IDLE.
REQ-017 A TXDATA write in IDLE with the buffer empty SHALL load the shifter directly; START SHALL begin next cycle, with tx low from the cycle after the write.
REQ-018 A TXDATA write while active SHALL fill the 1-entry holding buffer if it is empty.
REQ-019 A TXDATA write while buf_full SHALL be dropped and SHALL set sticky overflow; the exception is the final STOP cycle, where the buffer drains that same cycle and the new byte SHALL be accepted into the buffer.
REQ-020 A STATUS write with dmem_data_in[2]=1 SHALL clear overflow; a simultaneous set SHALL take priority over clear.
REQ-021 The bit counter SHALL run CLKS_PER_BIT-1 down to 0; the bit advances at 0; the index SHALL be 3 bits wrapping 7->0.
REQ-022 Back-to-back frames SHALL have no idle cycles between the stop bit and the next start bit.

Reset
REQ-023 On reset: state IDLE, tx=1, busy=0, buf_full=0, overflow=0, counters 0, dmem_data_out=0.
REQ-024 Reset asserted mid-frame SHALL abort the frame and discard the buffer; tx SHALL be 1 the cycle after reset is sampled.
REQ-025 Writes in a cycle where reset is high SHALL be ignored.

Structure
REQ-026 Package uart_pkg SHALL hold the state enum and the register offsets (TXDATA_OFS=0, STATUS_OFS=4) and the STATUS bit positions.
REQ-027 Baud timing SHALL be a sub-module baud_gen (clk, reset, restart in; tick out), instantiated once.

Verification (CLKS_PER_BIT=4)
REQ-028 Write 0x55 to TXDATA from idle -> tx 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles; busy high 40 cycles, then IDLE.
REQ-029 Write 0xA3 then 0x0F during the first frame -> STATUS reads 3'b011; the 0x0F start bit directly follows the 0xA3 stop bit; 80 cycles total.
REQ-030 Three writes during one frame -> third dropped; STATUS=3'b111; STATUS write 0x4 -> overflow clears, STATUS bit 2 reads 0.
REQ-031 Write to the buffer during the final STOP cycle with buf_full -> accepted; overflow stays 0; three frames sent contiguously.
REQ-032 reset at cycle 15 of a 0xFF frame -> tx=1 next cycle; STATUS=0; a following write of 0x01 sends a clean frame.
REQ-033 Write 0x12 to BASE_ADDR+8 (unselected) -> no frame; tx stays 1; the read of that address returns 0.
